// File: rtl/zero_run_expander.sv
// -----------------------------------------------------------------------------
// zero_run_expander
//
// Expands a zero-run-length encoded byte stream. A nonzero input byte is a
// literal and is passed through unchanged. A 0x00 byte is a run marker: the
// byte that follows it (N, 1..255) is expanded into N zero bytes. A count
// byte of 0x00 is malformed. It raises the sticky err flag, and decoding
// resumes with the next byte treated as a literal or marker.
//
// Input bytes pass through a small FIFO. A three-state FSM (LIT/CNT/RUN)
// consumes the FIFO head and loads a single registered output stage.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_data    encoded stream byte
//   in_valid   in_data valid this cycle
//   in_ready   FIFO has room (derived from occupancy only)
//   out_data   decoded byte (registered)
//   out_valid  out_data valid; held until out_ready
//   out_ready  downstream accepts out_data this cycle
//   busy       a count byte or zero run is pending (state != LIT)
//   err        sticky: a count byte of 0x00 was received
//   out_count  number of delivered output bytes, modulo 2^20
// -----------------------------------------------------------------------------
module zero_run_expander #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        err,
    output logic [19:0] out_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_LIT = 2'd0,
        ST_CNT = 2'd1,
        ST_RUN = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Input FIFO. The depth is a power of two, so the pointers wrap
    // naturally. The head is read combinationally so that the FSM can act
    // in the cycle after a byte is written.
    // ---------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          wr_en;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    head;

    assign in_ready   = (count_reg != (AW+1)'(FIFO_DEPTH));
    assign wr_en      = in_valid && in_ready;
    assign fifo_empty = (count_reg == '0);
    assign head       = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_reg] <= in_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // ---------------------------------------------------------------------
    // Decoder FSM
    // ---------------------------------------------------------------------
    state_t     state_reg;
    state_t     state_next;
    logic [7:0] run_cnt_reg;
    logic       out_valid_reg;
    logic [7:0] out_data_reg;
    logic       err_reg;
    logic [19:0] out_count_reg;

    // The output stage can take a new byte when it is empty or when its
    // current byte is leaving this cycle. This allows one byte per cycle.
    logic       out_free;
    logic       load;
    logic [7:0] load_data;
    logic       run_start;
    logic       run_step;
    logic       err_set;

    assign out_free = !out_valid_reg || out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_LIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LIT: begin
                if (!fifo_empty && out_free && (head == 8'h00)) begin
                    state_next = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!fifo_empty) begin
                    state_next = (head != 8'h00) ? ST_RUN : ST_LIT;
                end
            end
            ST_RUN: begin
                if (out_free && (run_cnt_reg == 8'd1)) begin
                    state_next = ST_LIT;
                end
            end
            default: state_next = ST_LIT;
        endcase
    end

    // Output / datapath control
    always_comb begin
        pop       = 1'b0;
        load      = 1'b0;
        load_data = 8'h00;
        run_start = 1'b0;
        run_step  = 1'b0;
        err_set   = 1'b0;
        case (state_reg)
            ST_LIT: begin
                if (!fifo_empty && out_free) begin
                    pop = 1'b1;
                    if (head != 8'h00) begin
                        load      = 1'b1;
                        load_data = head;
                    end
                end
            end
            ST_CNT: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head != 8'h00) begin
                        run_start = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (out_free) begin
                    load     = 1'b1;
                    run_step = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_reg <= 8'd0;
        end else if (run_start) begin
            run_cnt_reg <= head;
        end else if (run_step) begin
            run_cnt_reg <= run_cnt_reg - 8'd1;
        end
    end

    // Output register: a new load takes priority. Otherwise the byte is
    // dropped once the downstream accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'h00;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= load_data;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg       <= 1'b0;
            out_count_reg <= 20'd0;
        end else begin
            if (err_set) begin
                err_reg <= 1'b1;
            end
            if (out_valid_reg && out_ready) begin
                out_count_reg <= out_count_reg + 20'd1;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != ST_LIT);
    assign err       = err_reg;
    assign out_count = out_count_reg;

endmodule

// File: tb/tb_zero_run_expander.sv
module tb_zero_run_expander;

    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err;
    logic [19:0] out_count;

    int n_cmp;
    int n_bad;
    int busy_cycles;
    bit busy_en;
    logic [7:0] got_q[$];

    zero_run_expander #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output transfer. The inputs only change just after a
    // rising edge, so at the falling edge they already show what the next
    // edge will do.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                got_q.push_back(out_data);
                $display("xfer out_data=0x%02h", out_data);
            end
            if (busy_en && busy) begin
                busy_cycles++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check("wait_budget", 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    int lead_zeros;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        busy_cycles = 0;
        busy_en = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // ---- reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);

        // ---- literals, first output one edge after the FIFO write
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11;
        step();
        check("lit_no_early_valid", 32'(out_valid), 32'd0);
        in_data = 8'h22;
        step();
        check("lit_first", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
        in_data = 8'h33;
        step();
        check("lit_second", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
        in_valid = 1'b0;
        wait_q(3, 20);
        repeat (2) step();
        check("lit_n", 32'(got_q.size()), 32'd3);
        check("lit_q0", 32'(got_q[0]), 32'h11);
        check("lit_q1", 32'(got_q[1]), 32'h22);
        check("lit_q2", 32'(got_q[2]), 32'h33);
        check("lit_count", 32'(out_count), 32'd3);
        got_q.delete();

        // ---- short run: 05 00 03 07
        busy_cycles = 0;
        busy_en = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h05; step();
        in_data = 8'h00; step();
        in_data = 8'h03; step();
        check("run_busy_cnt", 32'(busy), 32'd1);
        in_data = 8'h07; step();
        in_valid = 1'b0;
        wait_q(5, 30);
        repeat (3) step();
        busy_en = 1'b0;
        check("run_n", 32'(got_q.size()), 32'd5);
        check("run_q0", 32'(got_q[0]), 32'h05);
        check("run_q1", 32'(got_q[1]), 32'h00);
        check("run_q2", 32'(got_q[2]), 32'h00);
        check("run_q3", 32'(got_q[3]), 32'h00);
        check("run_q4", 32'(got_q[4]), 32'h07);
        check("run_busy_cycles", 32'(busy_cycles), 32'd4);
        check("run_busy_end", 32'(busy), 32'd0);
        check("run_count", 32'(out_count), 32'd8);
        got_q.delete();

        // ---- backpressure: 00 FF, then fill the FIFO while stalled
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h00; step();
        in_data = 8'hFF; step();
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            in_data = 8'(i);
            step();
        end
        check("bp_full", 32'(in_ready), 32'd0);
        in_data = 8'h55;
        step();
        check("bp_still_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h00});
            step();
        end
        out_ready = 1'b1;
        wait_q(255 + FIFO_DEPTH, 600);
        repeat (5) step();
        check("bp_n", 32'(got_q.size()), 32'(255 + FIFO_DEPTH));
        lead_zeros = 0;
        while (lead_zeros < got_q.size() && got_q[lead_zeros] == 8'h00) lead_zeros++;
        check("bp_zeros", 32'(lead_zeros), 32'd255);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (255 + i < got_q.size()) begin
                check("bp_lit", 32'(got_q[255 + i]), 32'(i + 1));
            end
        end
        check("bp_count", 32'(out_count), 32'(8 + 255 + FIFO_DEPTH));
        got_q.delete();

        // ---- count byte of zero
        rst = 1'b1; step(); rst = 1'b0;
        send(8'h00);
        send(8'h00);
        send(8'h44);
        wait_q(1, 20);
        repeat (5) step();
        check("err_flag", 32'(err), 32'd1);
        check("err_n", 32'(got_q.size()), 32'd1);
        check("err_q0", 32'(got_q[0]), 32'h44);
        check("err_count", 32'(out_count), 32'd1);
        got_q.delete();

        // ---- reset in the middle of a run
        send(8'h00);
        send(8'h10);
        wait_q(4, 40);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        step();
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data", 32'(out_data), 32'h00);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        check("mrst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        got_q.delete();
        send(8'h09);
        wait_q(1, 20);
        repeat (20) step();
        check("mrst_n", 32'(got_q.size()), 32'd1);
        check("mrst_q0", 32'(got_q[0]), 32'h09);
        check("mrst_count", 32'(out_count), 32'd1);
        check("mrst_busy_end", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
